usb_link_mon: RTL and testbench
===============================

// Module: usb_link_mon
// PURPOSE
//  Parametrised USB full-speed link-state monitor. Generalises the fixed bus reset/suspend timeouts of the core top level.
//  Adds host-resume detection, remote-wakeup signalling with a line override, and an encoded event stream.
//  Sits between usb_phy (line state in, K override out) and the CSR/event logic of the core.
// PARAMETERS
//  T_RESET     480000  cycles of continuous SE0 to declare bus reset (10 ms @ 48 MHz)
//  T_SUSPEND   144000  cycles without activity to declare suspend (3 ms)
//  T_WAKE_IDLE 240000  minimum cycles in SUSPEND before remote wakeup is allowed (5 ms)
//  T_WAKE_DRV  96000   cycles the device drives K for remote wakeup (2 ms)
//  T_K_DEB     48      cycles of continuous K in SUSPEND to accept host resume (1 us)
//  CNT_W       20      counter width; must satisfy 2**CNT_W > every T_* value
// PORTS
//  clk         in   1  core clock (48 MHz)
//  rst_n       in   1  asynchronous, active-low reset
//  rx_dp       in   1  synchronised D+ line state from usb_phy
//  rx_dn       in   1  synchronised D- line state from usb_phy
//  rx_activity in   1  pulse: any line transition (phy rx_chg)
//  sof_stb     in   1  pulse: valid SOF packet start
//  wake_ena    in   1  remote wakeup enabled by host (level)
//  wake_req    in   1  pulse: software remote-wakeup request
//  tx_en       out  1  line override active
//  tx_dp       out  1  override D+ value
//  tx_dn       out  1  override D- value
//  link_state  out  3  current FSM state code
//  usb_reset   out  1  1 while in RESET
//  usb_suspend out  1  1 while in SUSPEND or WAKE_DRV
//  evt_stb     out  1  one-cycle event strobe
//  evt_code    out  3  event code, valid with evt_stb; holds its last value otherwise
// BEHAVIOUR
//  Line decode: SE0 = ~dp & ~dn; J = dp & ~dn; K = ~dp & dn.
//  Reset values (rst_n low): state ACTIVE; all counters 0; tx_en/tx_dp/tx_dn 0; evt_stb 0; evt_code 0; wake_pend 0.
//  Outputs are registered. State, flags and events change 1 cycle after the deciding input cycle.
//  se0_cnt: increments while SE0 and clears on non-SE0. At se0_cnt == T_RESET-1 with SE0 still present, go to RESET from any state except RESET.
//    Counter saturates; it does not wrap.
//  States and transitions (RESET entry above has priority over all other transitions):
//   ACTIVE(0): idle_cnt clears on rx_activity|sof_stb, otherwise increments. At T_SUSPEND-1 -> SUSPEND, evt SUSPEND.
//   RESET(1): on first non-SE0 cycle -> ACTIVE, evt RESET_END. Entry emits evt RESET_START.
//   SUSPEND(2): susp_cnt counts up from 0 on entry and saturates at T_WAKE_IDLE.
//    k_cnt counts continuous K and clears on non-K. At T_K_DEB-1 -> RESUME, evt RESUME.
//    If wake_pend & wake_ena & susp_cnt==T_WAKE_IDLE and no K is present -> WAKE_DRV.
//   WAKE_DRV(3): tx_en=1, tx_dp=0, tx_dn=1 (K). After T_WAKE_DRV cycles, tx_en drops and state -> RESUME, evt WAKE_DONE.
//    The SE0 check is masked while in WAKE_DRV.
//   RESUME(4): wait for the host to end K. On first non-K cycle -> ACTIVE with idle_cnt cleared. No timeout.
//  wake_pend: set by wake_req in any state.
//   Cleared on entry to WAKE_DRV, RESET or ACTIVE-from-RESUME, and whenever wake_ena=0.
//   A wake_req arriving in the same cycle as the clear wins (stays set).
//  Event codes: 1 SUSPEND, 2 RESUME (host-initiated), 3 RESET_START, 4 RESET_END, 5 WAKE_DONE.
//   At most one event per cycle; transitions are exclusive, so events never collide.
//  rst_n asserted mid-WAKE_DRV releases the override asynchronously (tx_en=0 immediately).
//  Invalid state codes 5-7 recover to ACTIVE on the next clock.
// STRUCTURE
//  usb_link_defs.vh: localparams for state codes (LS_ACTIVE..LS_RESUME) and event codes (LE_*), shared with CSR/event logic.
//  One sub-module: usb_link_tmr.
//   Saturating CNT_W-bit counter with clr/inc inputs and a done = (cnt == LIMIT-1) output.
//   Instantiated for se0, idle/susp (shared, cleared on state change), k and wake-drive timing.
// TESTING (bench params: T_RESET=40, T_SUSPEND=30, T_WAKE_IDLE=50, T_WAKE_DRV=20, T_K_DEB=4)
//  1. Hold J, no activity, 30 cycles -> evt SUSPEND, link_state=2, usb_suspend=1. Pulsing sof_stb every 20 cycles keeps state ACTIVE.
//  2. SE0 for 40 cycles -> evt RESET_START, usb_reset=1; then J -> evt RESET_END, state 0. SE0 for 39 cycles then J -> no event.
//  3. In SUSPEND, K for 3 cycles then J -> stays SUSPEND. K for 4 cycles -> evt RESUME; then J -> ACTIVE.
//  4. wake_ena=1, wake_req 10 cycles into SUSPEND -> tx_en rises at susp_cnt=50.
//     tx_en held exactly 20 cycles with dp=0/dn=1, then evt WAKE_DONE and state RESUME.
//  5. wake_req with wake_ena=0 -> no drive. wake_req pulsed in ACTIVE, then suspend -> WAKE_DRV after 50 cycles in SUSPEND.
//  6. rst_n low at cycle 5 of WAKE_DRV -> tx_en=0 combinationally, all outputs at reset values, state ACTIVE after release.

Source files
------------

// File: rtl/usb_link_mon_pkg.sv
// Shared state and event encodings for the USB full-speed link-state monitor.
// The CSR/event logic decodes link_state and evt_code with these same values.
package usb_link_mon_pkg;

  typedef enum logic [2:0] {
    LS_ACTIVE   = 3'd0,
    LS_RESET    = 3'd1,
    LS_SUSPEND  = 3'd2,
    LS_WAKE_DRV = 3'd3,
    LS_RESUME   = 3'd4
  } link_state_e;

  localparam logic [2:0] LE_NONE        = 3'd0;
  localparam logic [2:0] LE_SUSPEND     = 3'd1;
  localparam logic [2:0] LE_RESUME      = 3'd2;
  localparam logic [2:0] LE_RESET_START = 3'd3;
  localparam logic [2:0] LE_RESET_END   = 3'd4;
  localparam logic [2:0] LE_WAKE_DONE   = 3'd5;

endpackage

// File: rtl/usb_link_mon_tmr.sv
// Saturating up-counter with synchronous clear; done flags cnt == limit-1 and
// stays asserted while inc is held, since the count stops there.
module usb_link_mon_tmr #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = (cnt == (limit - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !done)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/usb_link_mon.sv
// USB full-speed link-state monitor: bus reset / suspend / resume detection,
// remote-wakeup K drive and an encoded one-cycle event stream.
//
//   state    | meaning
//   ACTIVE   | bus alive, watching for idle timeout
//   RESET    | SE0 held long enough, waiting for the line to leave SE0
//   SUSPEND  | bus idle, watching for host K or a pending remote wakeup
//   WAKE_DRV | device overrides the line with K
//   RESUME   | waiting for the host to release K
module usb_link_mon
  import usb_link_mon_pkg::*;
#(
  parameter int unsigned T_RESET     = 480000,
  parameter int unsigned T_SUSPEND   = 144000,
  parameter int unsigned T_WAKE_IDLE = 240000,
  parameter int unsigned T_WAKE_DRV  = 96000,
  parameter int unsigned T_K_DEB     = 48,
  parameter int          CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_dp,
  input  logic       rx_dn,
  input  logic       rx_activity,
  input  logic       sof_stb,
  input  logic       wake_ena,
  input  logic       wake_req,
  output logic       tx_en,
  output logic       tx_dp,
  output logic       tx_dn,
  output logic [2:0] link_state,
  output logic       usb_reset,
  output logic       usb_suspend,
  output logic       evt_stb,
  output logic [2:0] evt_code
);

  link_state_e state_q, state_d;
  logic        wake_pend_q, wake_pend_d, wake_clr;
  logic        evt_fire;
  logic [2:0]  evt_sel, evt_code_q;
  logic        evt_stb_q;
  logic        se0_done, idle_done, k_done, drv_done;
  logic        line_se0, line_k, state_chg;
  logic [CNT_W-1:0] idle_limit;

  assign line_se0  = ~rx_dp & ~rx_dn;
  assign line_k    = ~rx_dp &  rx_dn;
  assign state_chg = (state_d != state_q);

  // idle and suspend timing share one counter; the limit follows the state
  assign idle_limit = (state_q == LS_SUSPEND) ? CNT_W'(T_WAKE_IDLE + 1)
                                              : CNT_W'(T_SUSPEND);

  usb_link_mon_tmr #(.CNT_W(CNT_W)) u_se0_tmr (
    .clk(clk), .rst_n(rst_n), .clr(~line_se0), .inc(line_se0),
    .limit(CNT_W'(T_RESET)), .done(se0_done)
  );

  usb_link_mon_tmr #(.CNT_W(CNT_W)) u_idle_tmr (
    .clk(clk), .rst_n(rst_n),
    .clr(state_chg | ((state_q == LS_ACTIVE) & (rx_activity | sof_stb))),
    .inc(1'b1), .limit(idle_limit), .done(idle_done)
  );

  usb_link_mon_tmr #(.CNT_W(CNT_W)) u_k_tmr (
    .clk(clk), .rst_n(rst_n), .clr(~line_k | (state_q != LS_SUSPEND)), .inc(1'b1),
    .limit(CNT_W'(T_K_DEB)), .done(k_done)
  );

  usb_link_mon_tmr #(.CNT_W(CNT_W)) u_drv_tmr (
    .clk(clk), .rst_n(rst_n), .clr(state_q != LS_WAKE_DRV), .inc(1'b1),
    .limit(CNT_W'(T_WAKE_DRV)), .done(drv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LS_ACTIVE;
      wake_pend_q <= 1'b0;
      evt_stb_q   <= 1'b0;
      evt_code_q  <= LE_NONE;
    end else begin
      state_q     <= state_d;
      wake_pend_q <= wake_pend_d;
      evt_stb_q   <= evt_fire;
      if (evt_fire)
        evt_code_q <= evt_sel;
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_fire = 1'b0;
    evt_sel  = LE_NONE;
    // the device's own K drive masks the bus-reset check
    if (line_se0 && se0_done && state_q != LS_RESET && state_q != LS_WAKE_DRV) begin
      state_d  = LS_RESET;
      evt_fire = 1'b1;
      evt_sel  = LE_RESET_START;
    end else begin
      case (state_q)
        LS_ACTIVE:
          if (idle_done && !(rx_activity || sof_stb)) begin
            state_d  = LS_SUSPEND;
            evt_fire = 1'b1;
            evt_sel  = LE_SUSPEND;
          end
        LS_RESET:
          if (!line_se0) begin
            state_d  = LS_ACTIVE;
            evt_fire = 1'b1;
            evt_sel  = LE_RESET_END;
          end
        LS_SUSPEND:
          if (line_k && k_done) begin
            state_d  = LS_RESUME;
            evt_fire = 1'b1;
            evt_sel  = LE_RESUME;
          end else if (wake_pend_q && wake_ena && idle_done && !line_k) begin
            state_d = LS_WAKE_DRV;
          end
        LS_WAKE_DRV:
          if (drv_done) begin
            state_d  = LS_RESUME;
            evt_fire = 1'b1;
            evt_sel  = LE_WAKE_DONE;
          end
        LS_RESUME:
          if (!line_k)
            state_d = LS_ACTIVE;
        default:
          state_d = LS_ACTIVE;
      endcase
    end
  end

  // a request in the same cycle as a clear wins
  always_comb begin
    wake_clr = ~wake_ena
             | (state_chg & (state_d == LS_WAKE_DRV))
             | (state_chg & (state_d == LS_RESET))
             | ((state_q == LS_RESUME) & (state_d == LS_ACTIVE));
    wake_pend_d = wake_req | (wake_pend_q & ~wake_clr);
  end

  always_comb begin
    tx_en       = 1'b0;
    tx_dp       = 1'b0;
    tx_dn       = 1'b0;
    usb_reset   = 1'b0;
    usb_suspend = 1'b0;
    case (state_q)
      LS_RESET:    usb_reset = 1'b1;
      LS_SUSPEND:  usb_suspend = 1'b1;
      LS_WAKE_DRV: begin
        usb_suspend = 1'b1;
        tx_en       = 1'b1;
        tx_dn       = 1'b1;
      end
      default: ;
    endcase
  end

  assign link_state = state_q;
  assign evt_stb    = evt_stb_q;
  assign evt_code   = evt_code_q;

endmodule

// File: tb/tb_usb_link_mon.sv
// Directed bench for usb_link_mon with small timeouts; events are checked
// through an expected-event queue popped whenever evt_stb is seen.
module tb_usb_link_mon;
  import usb_link_mon_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_dp = 1'b1, rx_dn = 1'b0;
  logic rx_activity = 1'b0, sof_stb = 1'b0, wake_ena = 1'b0, wake_req = 1'b0;
  logic tx_en, tx_dp, tx_dn, usb_reset, usb_suspend, evt_stb;
  logic [2:0] link_state, evt_code;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  always #5 clk = ~clk;

  usb_link_mon #(
    .T_RESET(40), .T_SUSPEND(30), .T_WAKE_IDLE(50), .T_WAKE_DRV(20), .T_K_DEB(4), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_dp(rx_dp), .rx_dn(rx_dn),
    .rx_activity(rx_activity), .sof_stb(sof_stb), .wake_ena(wake_ena), .wake_req(wake_req),
    .tx_en(tx_en), .tx_dp(tx_dp), .tx_dn(tx_dn), .link_state(link_state),
    .usb_reset(usb_reset), .usb_suspend(usb_suspend), .evt_stb(evt_stb), .evt_code(evt_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input logic dp, input logic dn);
    rx_dp = dp;
    rx_dn = dn;
  endtask

  task automatic chk_state(input string tag, input link_state_e s);
    chk(tag, 32'(link_state), 32'(s));
  endtask

  // 7 is never a legal code, so an event with nothing expected fails
  always @(negedge clk) begin
    if (rst_n && evt_stb) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
      chk("evt_code", 32'(evt_code), 32'(mon_exp));
    end
  end

  initial begin
    line(1, 0);
    tick(3);
    chk_state("rst_state", LS_ACTIVE);
    chk("rst_tx", 32'({tx_en, tx_dp, tx_dn}), 32'(0));
    chk("rst_evt", 32'({evt_stb, evt_code}), 32'(0));
    chk("rst_flags", 32'({usb_reset, usb_suspend}), 32'(0));
    rst_n = 1'b1;

    // idle J -> suspend after 30 cycles
    tick(29);
    chk_state("t1_pre_susp", LS_ACTIVE);
    exp_q.push_back(LE_SUSPEND);
    tick(1);
    chk_state("t1_susp", LS_SUSPEND);
    chk("t1_usb_suspend", 32'(usb_suspend), 32'(1));
    chk("t1_evt_stb", 32'(evt_stb), 32'(1));

    // short K is ignored, 4 cycles of K resumes
    line(0, 1); tick(3); line(1, 0); tick(1);
    chk_state("t3_short_k", LS_SUSPEND);
    line(0, 1);
    exp_q.push_back(LE_RESUME);
    tick(3);
    chk_state("t3_k3", LS_SUSPEND);
    tick(1);
    chk_state("t3_resume", LS_RESUME);
    line(1, 0); tick(1);
    chk_state("t3_active", LS_ACTIVE);

    // SOF every 20 cycles keeps the link active
    for (int p = 0; p < 3; p++) begin
      tick(19); sof_stb = 1'b1; tick(1); sof_stb = 1'b0;
    end
    chk_state("t1_sof_keep", LS_ACTIVE);

    // 39 cycles of SE0 is not a reset
    rx_activity = 1'b1; line(0, 0); tick(39);
    chk("t2_se0_39", 32'(usb_reset), 32'(0));
    line(1, 0); rx_activity = 1'b0; tick(1);
    chk_state("t2_se0_39_j", LS_ACTIVE);

    // 40 cycles of SE0 is a reset
    rx_activity = 1'b1; line(0, 0);
    exp_q.push_back(LE_RESET_START);
    tick(40);
    chk_state("t2_reset", LS_RESET);
    chk("t2_usb_reset", 32'(usb_reset), 32'(1));
    tick(5);
    chk_state("t2_reset_hold", LS_RESET);
    line(1, 0); rx_activity = 1'b0;
    exp_q.push_back(LE_RESET_END);
    tick(1);
    chk_state("t2_reset_end", LS_ACTIVE);
    tick(1);
    chk("t2_code_hold", 32'({evt_stb, evt_code}), 32'({1'b0, LE_RESET_END}));

    // remote wakeup: request 10 cycles into suspend, drive at susp_cnt 50
    wake_ena = 1'b1;
    tick(28);
    exp_q.push_back(LE_SUSPEND);
    tick(1);
    chk_state("t4_susp", LS_SUSPEND);
    tick(10); wake_req = 1'b1; tick(1); wake_req = 1'b0;
    tick(39);
    chk("t4_tx_pre", 32'(tx_en), 32'(0));
    tick(1);
    chk_state("t4_wake_drv", LS_WAKE_DRV);
    chk("t4_tx_k", 32'({tx_en, tx_dp, tx_dn}), 32'(3'b101));
    chk("t4_usb_suspend", 32'(usb_suspend), 32'(1));
    line(0, 1);
    exp_q.push_back(LE_WAKE_DONE);
    for (int i = 0; i < 19; i++) begin
      tick(1);
      chk("t4_tx_hold", 32'({tx_en, tx_dp, tx_dn}), 32'(3'b101));
    end
    tick(1);
    chk("t4_tx_drop", 32'(tx_en), 32'(0));
    chk_state("t4_resume", LS_RESUME);
    tick(3);
    chk_state("t4_resume_k", LS_RESUME);
    line(1, 0); tick(1);
    chk_state("t4_active", LS_ACTIVE);

    // request with wakeup disabled never drives
    wake_ena = 1'b0; wake_req = 1'b1; tick(1); wake_req = 1'b0;
    tick(28);
    exp_q.push_back(LE_SUSPEND);
    tick(1);
    chk_state("t5_susp", LS_SUSPEND);
    tick(55);
    chk_state("t5_no_wake", LS_SUSPEND);
    chk("t5_no_tx", 32'(tx_en), 32'(0));
    line(0, 1);
    exp_q.push_back(LE_RESUME);
    tick(4);
    chk_state("t5_resume", LS_RESUME);
    line(1, 0); tick(1);
    chk_state("t5_active", LS_ACTIVE);

    // request made in ACTIVE is remembered across suspend entry
    wake_ena = 1'b1; wake_req = 1'b1; tick(1); wake_req = 1'b0;
    tick(28);
    exp_q.push_back(LE_SUSPEND);
    tick(1);
    chk_state("t5_susp2", LS_SUSPEND);
    tick(50);
    chk("t5_tx_pre", 32'(tx_en), 32'(0));
    tick(1);
    chk_state("t5_wake_drv", LS_WAKE_DRV);
    chk("t5_tx_on", 32'(tx_en), 32'(1));

    // async reset mid-drive releases the override at once
    tick(5);
    chk_state("t6_in_drive", LS_WAKE_DRV);
    rst_n = 1'b0;
    #1;
    chk("t6_tx_async", 32'({tx_en, tx_dp, tx_dn}), 32'(0));
    chk_state("t6_state_async", LS_ACTIVE);
    chk("t6_evt_async", 32'({evt_stb, evt_code}), 32'(0));
    chk("t6_flags_async", 32'({usb_reset, usb_suspend}), 32'(0));
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_state("t6_after", LS_ACTIVE);
    chk("t6_tx_after", 32'(tx_en), 32'(0));

    chk("evt_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
